// File: rtl/mulpop_arbiter.sv
// mulpop_arbiter: round-robin arbiter in front of a serial shift-and-add
// multiplier. It reports the low 32 product bits, their population count,
// and whether any product bits above bit 31 are set.
module mulpop_arbiter #(
  parameter int OP_W = 24
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            req0,
  input  logic            req1,
  input  logic [OP_W-1:0] a0,
  input  logic [OP_W-1:0] b0,
  input  logic [OP_W-1:0] a1,
  input  logic [OP_W-1:0] b1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            done0,
  output logic            done1,
  output logic [31:0]     result,
  output logic [5:0]      ones,
  output logic            ovf,
  output logic            busy
);

  localparam int CNT_W  = $clog2(OP_W + 1);
  localparam int PROD_W = 2 * OP_W;

  typedef enum logic [1:0] {IDLE, MUL, CNT, RESP} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                w_grant0;
  logic                w_grant1;
  logic [PROD_W-1:0]   r_acc;
  logic [PROD_W-1:0]   r_mcand;
  logic [OP_W-1:0]     r_mplr;
  logic [CNT_W-1:0]    r_bitCnt;
  logic                r_owner;
  logic                r_prio1;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_done0;
  logic                r_done1;
  logic [31:0]         r_result;
  logic [5:0]          r_ones;
  logic                r_ovf;
  logic [5:0]          r_onesCalc;
  logic                r_ovfCalc;
  logic [63:0]         w_accWide;
  logic [5:0]          w_popCnt;
  logic                w_hiNonZero;

  // Zero-extend the accumulator to 64 bits so the low/high split at bit 32
  // stays legal for any operand width up to 32.
  assign w_accWide   = 64'(r_acc);
  assign w_hiNonZero = |w_accWide[63:32];

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign done0  = r_done0;
  assign done1  = r_done1;
  assign result = r_result;
  assign ones   = r_ones;
  assign ovf    = r_ovf;
  assign busy   = (r_state != IDLE);

  // Population count of the low 32 accumulator bits.
  always_comb begin
    w_popCnt = '0;
    for (int i = 0; i < 32; i++) begin
      w_popCnt = w_popCnt + {5'd0, w_accWide[i]};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state plus the round-robin grant decision.
  // Requests are only looked at in IDLE. A request raised while busy simply
  // stays pending.
  always_comb begin
    w_nextState = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 && (!req1 || !r_prio1)) begin
          w_grant0    = 1'b1;
          w_nextState = MUL;
        end else if (req1) begin
          w_grant1    = 1'b1;
          w_nextState = MUL;
        end
      end
      MUL: begin
        if (r_bitCnt == CNT_W'(OP_W - 1)) begin
          w_nextState = CNT;
        end
      end
      CNT:     w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operand capture, serial multiply, bit counting and result publication.
  // done is registered on the RESP->IDLE edge, so the done cycle is already
  // IDLE and a pending request can be granted at the very next edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplr     <= '0;
      r_bitCnt   <= '0;
      r_owner    <= 1'b0;
      r_prio1    <= 1'b0;
      r_result   <= '0;
      r_ones     <= '0;
      r_ovf      <= 1'b0;
      r_onesCalc <= '0;
      r_ovfCalc  <= 1'b0;
    end else begin
      r_gnt0  <= w_grant0;
      r_gnt1  <= w_grant1;
      r_done0 <= (r_state == RESP) && !r_owner;
      r_done1 <= (r_state == RESP) && r_owner;
      if (w_grant0 || w_grant1) begin
        r_acc    <= '0;
        r_bitCnt <= '0;
        r_owner  <= w_grant1;
        r_prio1  <= w_grant0;
        r_mcand  <= {{OP_W{1'b0}}, (w_grant1 ? a1 : a0)};
        r_mplr   <= w_grant1 ? b1 : b0;
      end
      if (r_state == MUL) begin
        if (r_mplr[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplr   <= r_mplr >> 1;
        r_bitCnt <= r_bitCnt + CNT_W'(1);
      end
      if (r_state == CNT) begin
        r_onesCalc <= w_popCnt;
        r_ovfCalc  <= w_hiNonZero;
      end
      if (r_state == RESP) begin
        r_result <= w_accWide[31:0];
        r_ones   <= r_onesCalc;
        r_ovf    <= r_ovfCalc;
      end
    end
  end

endmodule

// File: tb/tb_mulpop_arbiter.sv
// tb_mulpop_arbiter: directed scenarios and random traffic.
// The reference model is a job timer plus a plain 64-bit multiply.
module tb_mulpop_arbiter;

  localparam int OP_W = 24;

  logic            clk = 1'b0;
  logic            n_reset;
  logic            req0, req1;
  logic [OP_W-1:0] a0, b0, a1, b1;
  logic            gnt0, gnt1, done0, done1;
  logic [31:0]     result;
  logic [5:0]      ones;
  logic            ovf, busy;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: the cycles left in the current job, the round-robin
  // preference, the captured product and the expected outputs.
  int          mTimer;
  bit          mPrio1;
  bit          mOwner;
  logic [63:0] mProd;
  bit          eGnt0, eGnt1, eDone0, eDone1, eOvf, eBusy;
  logic [31:0] eResult;
  logic [5:0]  eOnes;
  bit          hold0, hold1;
  string       phase;

  mulpop_arbiter #(.OP_W(OP_W)) dut (
    .clk(clk), .n_reset(n_reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .ones(ones), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    mTimer  = 0;
    mPrio1  = 1'b0;
    mOwner  = 1'b0;
    mProd   = '0;
    eGnt0   = 1'b0; eGnt1  = 1'b0;
    eDone0  = 1'b0; eDone1 = 1'b0;
    eResult = '0;   eOnes  = '0; eOvf = 1'b0;
    eBusy   = 1'b0;
  endtask

  // One rising edge of the reference model.
  // A job takes OP_W+2 cycles from its grant to its done.
  // The done cycle is idle again.
  task automatic modelStep();
    eGnt0  = 1'b0; eGnt1  = 1'b0;
    eDone0 = 1'b0; eDone1 = 1'b0;
    if (mTimer == 0) begin
      if (req0 && (!req1 || !mPrio1)) begin
        mOwner = 1'b0; mProd = 64'(a0) * 64'(b0);
        eGnt0  = 1'b1; mPrio1 = 1'b1; mTimer = OP_W + 2;
      end else if (req1) begin
        mOwner = 1'b1; mProd = 64'(a1) * 64'(b1);
        eGnt1  = 1'b1; mPrio1 = 1'b0; mTimer = OP_W + 2;
      end
    end else begin
      mTimer--;
      if (mTimer == 0) begin
        if (mOwner) eDone1 = 1'b1; else eDone0 = 1'b1;
        eResult = mProd[31:0];
        eOnes   = 6'($countones(mProd[31:0]));
        eOvf    = (mProd[63:32] != 0);
      end
    end
    eBusy = (mTimer != 0);
  endtask

  // Advance one clock.
  // The model steps on the rising edge. The DUT is compared on the falling
  // edge. A requester drops its request after its grant unless it holds it.
  task automatic applyStimulus();
    @(posedge clk);
    if (n_reset) modelStep(); else modelReset();
    @(negedge clk);
    checkOutput({phase, ".gnt0"},   64'(gnt0),   64'(eGnt0));
    checkOutput({phase, ".gnt1"},   64'(gnt1),   64'(eGnt1));
    checkOutput({phase, ".done0"},  64'(done0),  64'(eDone0));
    checkOutput({phase, ".done1"},  64'(done1),  64'(eDone1));
    checkOutput({phase, ".busy"},   64'(busy),   64'(eBusy));
    checkOutput({phase, ".result"}, 64'(result), 64'(eResult));
    checkOutput({phase, ".ones"},   64'(ones),   64'(eOnes));
    checkOutput({phase, ".ovf"},    64'(ovf),    64'(eOvf));
    if (eGnt0 && !hold0) req0 = 1'b0;
    if (eGnt1 && !hold1) req1 = 1'b0;
  endtask

  // Run one job from the chosen requester against constant expectations.
  // The operand a can optionally be changed right after the grant.
  task automatic runJob(input string name, input bit who,
                        input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                        input bit changeA, input logic [OP_W-1:0] aLate,
                        input logic [31:0] expRes, input logic [5:0] expOnes, input bit expOvf);
    int gntAt  = -1;
    int doneAt = -1;
    phase = name;
    if (who) begin req1 = 1'b1; a1 = a; b1 = b; end
    else     begin req0 = 1'b1; a0 = a; b0 = b; end
    for (int c = 0; c < 200 && doneAt < 0; c++) begin
      applyStimulus();
      if (gntAt < 0 && (who ? gnt1 : gnt0)) begin
        gntAt = c;
        if (changeA) begin
          if (who) a1 = aLate; else a0 = aLate;
        end
      end
      if (who ? done1 : done0) doneAt = c;
    end
    if (gntAt < 0 || doneAt < 0) begin
      checkOutput({name, ".timeout"}, 64'(0), 64'(1));
    end else begin
      checkOutput({name, ".latency"}, 64'(doneAt - gntAt), 64'(OP_W + 2));
      checkOutput({name, ".resultK"}, 64'(result), 64'(expRes));
      checkOutput({name, ".onesK"},   64'(ones),   64'(expOnes));
      checkOutput({name, ".ovfK"},    64'(ovf),    64'(expOvf));
    end
  endtask

  function automatic logic [OP_W-1:0] pickOp();
    case ($urandom % 4)
      0:       pickOp = '0;
      1:       pickOp = '1;
      default: pickOp = OP_W'($urandom);
    endcase
  endfunction

  initial begin
    bit q[$];
    int seenGnt;
    n_reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    hold0 = 1'b0; hold1 = 1'b0;
    phase = "reset";
    modelReset();
    repeat (3) applyStimulus();
    n_reset = 1'b1;
    applyStimulus();

    // Directed jobs: small product, full-scale operands, high-only product,
    // zero operand, and an operand change after capture.
    runJob("small", 1'b0, 24'd3, 24'd5, 1'b0, '0, 32'h0000000F, 6'd4, 1'b0);
    runJob("max1",  1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, '0, 32'hFE000001, 6'd8, 1'b1);
    runJob("hiOnly", 1'b0, 24'h010000, 24'h010000, 1'b0, '0, 32'h0, 6'd0, 1'b1);
    runJob("zero",  1'b0, 24'd0, 24'h123456, 1'b0, '0, 32'h0, 6'd0, 1'b0);
    runJob("late",  1'b0, 24'd3, 24'd5, 1'b1, 24'd9, 32'd15, 6'd4, 1'b0);

    // Both requesters continuously asserted from reset release.
    phase = "rr";
    n_reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; hold0 = 1'b1; hold1 = 1'b1;
    a0 = 24'd3; b0 = 24'd5; a1 = 24'd7; b1 = 24'd11;
    repeat (2) applyStimulus();
    n_reset = 1'b1;
    for (int c = 0; c < 3 * (OP_W + 3) + 4; c++) begin
      applyStimulus();
      if (gnt0) q.push_back(1'b0);
      if (gnt1) q.push_back(1'b1);
    end
    if (q.size() < 3) begin
      checkOutput("rr.grantCount", 64'(q.size()), 64'(3));
    end else begin
      checkOutput("rr.first",  64'(q[0]), 64'(0));
      checkOutput("rr.second", 64'(q[1]), 64'(1));
      checkOutput("rr.third",  64'(q[2]), 64'(0));
    end
    hold0 = 1'b0; hold1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2 * (OP_W + 3)) applyStimulus();

    // Reset pulse 10 cycles into a multiply aborts the job.
    phase = "abort";
    req0 = 1'b1; a0 = 24'd3; b0 = 24'd5;
    seenGnt = 0;
    for (int c = 0; c < 5 && seenGnt == 0; c++) begin
      applyStimulus();
      if (gnt0) seenGnt = 1;
    end
    checkOutput("abort.gntSeen", 64'(seenGnt), 64'(1));
    repeat (10) applyStimulus();
    n_reset = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("abort.busyK", 64'(busy), 64'(0));
    n_reset = 1'b1;
    repeat (OP_W + 6) applyStimulus();
    runJob("afterAbort", 1'b0, 24'd2, 24'd7, 1'b0, '0, 32'd14, 6'd3, 1'b0);

    // Random traffic: requests, withdrawals and held requests.
    phase = "rand";
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      if (c % 400 == 0) begin
        hold0 = ($urandom % 3 == 0);
        hold1 = ($urandom % 3 == 0);
      end
      if (!req0) begin
        if ($urandom % 6 == 0) begin req0 = 1'b1; a0 = pickOp(); b0 = pickOp(); end
      end else if ($urandom % 40 == 0) begin
        req0 = 1'b0;
      end
      if (!req1) begin
        if ($urandom % 6 == 0) begin req1 = 1'b1; a1 = pickOp(); b1 = pickOp(); end
      end else if ($urandom % 40 == 0) begin
        req1 = 1'b0;
      end
      if (c == 1777) n_reset = 1'b0;
      if (c == 1779) n_reset = 1'b1;
    end
    hold0 = 1'b0; hold1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2 * (OP_W + 3)) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mulpop_arbiter.md
MULPOP_ARBITER -- requirements
Module: mulpop_arbiter

Interface
REQ-001 SHALL have parameter OP_W, default 24, operand width in bits; product width 2*OP_W; result fixed 32 bits.
REQ-002 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port n_reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0 / req1  input  1  job request from requester 0 / 1, level, held until granted.
REQ-005 SHALL have ports a0, b0 / a1, b1  input  OP_W  multiplicand / multiplier of requester 0 / 1.
REQ-006 SHALL have ports gnt0 / gnt1  output  1  one-cycle pulse: job accepted, operands captured.
REQ-007 SHALL have ports done0 / done1  output  1  one-cycle pulse: result for requester 0 / 1 valid.
REQ-008 SHALL have port result  output  32  product[31:0] of last completed job.
REQ-009 SHALL have port ones  output  6  population count of result, 0..32.
REQ-010 SHALL have port ovf  output  1  high when product[2*OP_W-1:32] is non-zero.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, CNT, RESP; IDLE->MUL on grant, MUL->CNT after OP_W cycles, CNT->RESP after 1 cycle, RESP->IDLE after 1 cycle.
REQ-013 SHALL sample req0/req1 only in IDLE; requests asserted outside IDLE stay pending, are not lost, and are not queued.
REQ-014 SHALL arbitrate round-robin: single request granted directly; both requesting -> grant the requester not served last; pointer after reset favours requester 0.
REQ-015 SHALL, at the edge granting a job, capture that requester's operands and requester index, and assert the matching gnt for exactly the next cycle.
REQ-016 SHALL NOT assert both gnt0 and gnt1, or both done0 and done1, in the same cycle.
REQ-017 SHALL multiply serially in MUL, one multiplier bit per cycle, LSB first, shift-and-add into a 2*OP_W accumulator; operand changes after capture have no effect.
REQ-018 SHALL, in CNT, compute ones over accumulator[31:0] and ovf over accumulator[2*OP_W-1:32].
REQ-019 SHALL update result, ones, ovf at the same edge that raises done; the three hold their values until the next done.
REQ-020 SHALL raise done of the captured requester exactly OP_W+2 cycles after gnt rises (26 cycles with default OP_W).
REQ-021 SHALL return to IDLE while done is high, so a pending request is granted the cycle after done (back-to-back throughput: one job per OP_W+3 cycles).
REQ-022 SHALL treat req dropped before gnt as withdrawn: no job started, no gnt issued.
REQ-023 SHALL handle operand zero (either) as a normal OP_W-cycle job: result 0, ones 0, ovf 0.
REQ-024 SHALL bound wait: a continuously asserted request is granted within 2*(OP_W+3) cycles when the other requester also requests continuously.

Reset
REQ-025 SHALL, while n_reset low, force state IDLE, gnt0/gnt1/done0/done1 0, busy 0, result 0, ones 0, ovf 0, accumulator 0, round-robin pointer to favour requester 0.
REQ-026 SHALL abort any job in progress on reset assertion; no done is issued for an aborted job.
REQ-027 SHALL sample requests again starting at the first rising clk edge after n_reset deasserts.

Verification
REQ-028 SHALL cover: req0 with a0=3, b0=5 -> gnt0 one cycle, done0 26 cycles later, result 0x0000000F, ones 4, ovf 0.
REQ-029 SHALL cover: req1 with a1=b1=0xFFFFFF -> done1, result 0xFE000001, ones 8, ovf 1.
REQ-030 SHALL cover: req0 with a0=b0=0x010000 -> result 0x00000000, ones 0, ovf 1.
REQ-031 SHALL cover: req0 and req1 both high from reset release -> gnt0 first, gnt1 the cycle after done0, gnt0 the cycle after done1; never simultaneous grants.
REQ-032 SHALL cover: n_reset pulsed low 10 cycles into MUL -> no done pulse, all outputs 0; a new req0 with a0=2, b0=7 then yields result 14, ones 3.
REQ-033 SHALL cover: a0 changed from 3 to 9 on the cycle after gnt0 with b0=5 -> result 15, not 45.
